// File: rtl/screen_rotate_multi.sv
// screen_rotate_multi
//   Runtime-selectable frame rotator (0/90/180/270 degrees plus horizontal
//   mirror) that sits between an arcade core and the scaler. Input frames are
//   written linearly into a multi-bank frame buffer. The output side reads the
//   most recently completed frame in transformed order, using its own line and
//   frame timing. That timing only suits the scaler, not a TV or VGA monitor.
//
// Build option:
//   SCREEN_ROTATE_TRIPLE_BUF_EN - defined: 3 banks. The writer never targets
//                                 the bank being displayed, and frame_drop
//                                 reports unread frames that get overwritten.
//                                 undefined: 2 banks. The writer toggles banks,
//                                 so tearing is possible, and frame_drop is 0.
//
// Ports:
//   clk, reset                - video clock, synchronous active-high reset
//   ce, video_in              - input pixel enable and pixel data
//   hblank, vblank            - input blanking
//   rotate, flip              - transform select, sampled at output frame start
//   ce_out                    - output pixel enable
//   video_out                 - output pixel, 2 clk after the issuing ce_out tick
//   hsync, vsync              - output syncs
//   hblank_out, vblank_out    - output blanking
//   frame_drop                - 1-clk pulse when an unread completed frame is replaced
module screen_rotate_multi #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DEPTH  = 8,
  parameter int MARGIN = 4,
  parameter int HBL    = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank,
  input  logic             vblank,
  input  logic [1:0]       rotate,
  input  logic             flip,
  input  logic             ce_out,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank_out,
  output logic             vblank_out,
  output logic             frame_drop
);

`ifdef SCREEN_ROTATE_TRIPLE_BUF_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int B    = WIDTH * HEIGHT;
  localparam int AW   = $clog2(NB * B);
  localparam int MAXD = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int CW   = $clog2(MAXD + HBL + 2 * MARGIN + 1);
  localparam int XW   = $clog2(WIDTH + 1);
  localparam int YW   = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {S_WAIT, S_ACTIVE, S_VBL} state_t;

  logic [DEPTH-1:0] r_mem [0:NB*B-1];

  // ---------------- write side ----------------
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_blank_d, r_vb_d, r_sync, r_wrote, r_done_valid;
  logic [1:0]    r_wbank, r_last_done, w_wbank_next;
  logic          w_blank_rise, w_vb_rise, w_we;
  logic [AW-1:0] w_waddr;

  // ---------------- read side ----------------
  state_t        r_state;
  logic [CW-1:0] r_h, r_vline;
  logic [3:0]    r_vbcnt;
  logic [1:0]    r_rot, r_rbank;
  logic          r_flip;
  logic [AW-1:0] r_addr;
  logic          r_hb_p1, r_hs_p1, r_vb_p1, r_vs_p1, r_black_p1;
  logic [CW-1:0] w_ow, w_oh;
  logic          w_eol, w_latch, w_hb, w_hs, w_vs, w_black, w_last_line;
  logic [AW-1:0] w_u, w_v, w_up, w_src, w_raddr;

  assign w_blank_rise = (hblank | vblank) & ~r_blank_d;
  assign w_vb_rise    = vblank & ~r_vb_d;
  // r_sync holds off writes after reset until a vblank is seen, so that a
  // partially written frame is never completed.
  assign w_we    = ce & ~hblank & ~vblank & r_sync &
                   (r_x < XW'(WIDTH)) & (r_y < YW'(HEIGHT));
  assign w_waddr = AW'(r_wbank) * AW'(B) + AW'(r_y) * AW'(WIDTH) + AW'(r_x);

`ifdef SCREEN_ROTATE_TRIPLE_BUF_EN
  logic       r_frame_drop;
  logic [1:0] w_rb_eff;
  // If the reader grabs last_done in this same clock, that bank becomes the
  // displayed one. The free bank is then the one the reader is releasing.
  assign w_rb_eff     = w_latch ? r_last_done : r_rbank;
  assign w_wbank_next = 2'd3 - r_wbank - w_rb_eff;
  assign frame_drop   = r_frame_drop;

  always_ff @(posedge clk) begin
    if (reset) r_frame_drop <= 1'b0;
    else       r_frame_drop <= w_vb_rise & r_wrote & r_done_valid &
                               (r_last_done != r_rbank) & ~w_latch;
  end
`else
  assign w_wbank_next = (r_wbank == 2'd0) ? 2'd1 : 2'd0;
  assign frame_drop   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_blank_d    <= 1'b1;
      r_vb_d       <= 1'b1;
      r_sync       <= 1'b0;
      r_wrote      <= 1'b0;
      r_done_valid <= 1'b0;
      r_wbank      <= 2'd0;
      r_last_done  <= 2'd0;
    end else begin
      r_blank_d <= hblank | vblank;
      r_vb_d    <= vblank;
      if (vblank) r_sync <= 1'b1;
      if (w_we) begin
        r_x     <= r_x + XW'(1);
        r_wrote <= 1'b1;
      end
      if (w_blank_rise) begin
        r_x <= '0;
        if (r_y != YW'(HEIGHT)) r_y <= r_y + YW'(1);
      end
      if (w_vb_rise) begin
        r_y     <= '0;
        r_wrote <= 1'b0;
        if (r_wrote) begin
          r_last_done  <= r_wbank;
          r_done_valid <= 1'b1;
          r_wbank      <= w_wbank_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= video_in;
  end

  // ---------------- output geometry and address ----------------
  assign w_ow        = r_rot[0] ? CW'(HEIGHT) : CW'(WIDTH);
  assign w_oh        = r_rot[0] ? CW'(WIDTH)  : CW'(HEIGHT);
  assign w_eol       = ce_out & (r_h == w_ow + CW'(HBL - 1));
  assign w_latch     = w_eol & r_done_valid & (r_last_done != r_rbank);
  assign w_last_line = (r_vline == w_oh + CW'(2 * MARGIN - 1));

  assign w_u  = AW'(r_h);
  assign w_v  = AW'(r_vline - CW'(MARGIN));
  assign w_up = r_flip ? (AW'(w_ow) - AW'(1) - w_u) : w_u;

  always_comb begin
    w_src = '0;
    case (r_rot)
      2'd0: w_src = w_v * AW'(WIDTH) + w_up;
      2'd1: w_src = (AW'(HEIGHT - 1) - w_up) * AW'(WIDTH) + w_v;
      2'd2: w_src = (AW'(HEIGHT - 1) - w_v) * AW'(WIDTH) + (AW'(WIDTH - 1) - w_up);
      default: w_src = w_up * AW'(WIDTH) + (AW'(WIDTH - 1) - w_v);
    endcase
  end
  assign w_raddr = AW'(r_rbank) * AW'(B) + w_src;

  assign w_hb    = (r_h >= w_ow);
  assign w_hs    = (r_h >= w_ow + CW'(8)) & (r_h < w_ow + CW'(10));
  assign w_vs    = (r_state == S_VBL) & (r_vbcnt >= 4'd10) & (r_vbcnt <= 4'd11);
  assign w_black = (r_state != S_ACTIVE) | w_hb | (r_vline < CW'(MARGIN)) |
                   (r_vline >= w_oh + CW'(MARGIN));

  // Read FSM plus a 2-stage pipeline: the tick stage registers the address and
  // flags, and the next clock presents the pixel and flags together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_WAIT;
      r_h        <= '0;
      r_vline    <= '0;
      r_vbcnt    <= '0;
      r_rot      <= 2'd0;
      r_flip     <= 1'b0;
      r_rbank    <= 2'(NB - 1);
      r_addr     <= '0;
      r_hb_p1    <= 1'b1;
      r_hs_p1    <= 1'b0;
      r_vb_p1    <= 1'b1;
      r_vs_p1    <= 1'b0;
      r_black_p1 <= 1'b1;
      hblank_out <= 1'b1;
      hsync      <= 1'b0;
      vblank_out <= 1'b1;
      vsync      <= 1'b0;
    end else begin
      if (ce_out) begin
        r_addr     <= w_raddr;
        r_hb_p1    <= w_hb;
        r_hs_p1    <= w_hs;
        r_vb_p1    <= (r_state != S_ACTIVE);
        r_vs_p1    <= w_vs;
        r_black_p1 <= w_black;
        r_h        <= w_eol ? '0 : r_h + CW'(1);
        if (w_latch) begin
          r_rot   <= rotate;
          r_flip  <= flip;
          r_rbank <= r_last_done;
          r_vline <= '0;
          r_state <= S_ACTIVE;
        end else if (w_eol) begin
          case (r_state)
            S_ACTIVE: begin
              if (w_last_line) begin
                r_state <= S_VBL;
                r_vbcnt <= '0;
              end else begin
                r_vline <= r_vline + CW'(1);
              end
            end
            // Saturate so a long idle VBL does not repeat the vsync pulse.
            S_VBL:   if (r_vbcnt != 4'd15) r_vbcnt <= r_vbcnt + 4'd1;
            default: ;
          endcase
        end
      end
      hblank_out <= r_hb_p1;
      hsync      <= r_hs_p1;
      vblank_out <= r_vb_p1;
      vsync      <= r_vs_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) video_out <= '0;
    else       video_out <= r_black_p1 ? '0 : r_mem[r_addr];
  end

endmodule
